uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter OVERSAMPLE, default 16, ticks per bit period; fixed at 16 (4-bit sample counter).
REQ-002 Parameter DATA_BITS, default 8, data bits per frame, LSB first.
REQ-003 clk  input  1  system clock (100 MHz); all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 tick  input  1  1-cycle enable at OVERSAMPLE x baud rate, from the baud divider.
REQ-006 rxd  input  1  asynchronous serial line, idle high.
REQ-007 data  output  8  last correctly received byte.
REQ-008 data_valid  output  1  1-cycle pulse, new byte on data.
REQ-009 frame_err  output  1  1-cycle pulse, stop bit sampled low.
REQ-010 busy  output  1  high in any state other than IDLE.

Function
REQ-011 rxd shall pass through a 2-flop synchronizer (reset value 1); all FSM decisions use the synchronized value rxs.
REQ-012 States shall be IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-013 The FSM, sample counter (4 bit) and bit index (3 bit) shall change only on cycles with tick=1; the synchronizer runs every cycle.
REQ-014 IDLE: on tick with rxs=0, go to START with counter cleared to 0.
REQ-015 START: counter increments per tick; on the tick with counter=7 (mid start bit), go to DATA with counter and bit index cleared if rxs=0, else to IDLE (glitch reject, no output pulse).
REQ-016 DATA: counter increments per tick; on the tick with counter=15, shift rxs into the MSB of the shift register (right shift, LSB-first), clear the counter, increment the bit index; after the bit with index 7, go to STOP.
REQ-017 STOP: on the tick with counter=15: if rxs=1, load data from the shift register, pulse data_valid, go to IDLE; if rxs=0, pulse frame_err, leave data unchanged, go to WAIT_HIGH.
REQ-018 WAIT_HIGH: on tick with rxs=1 go to IDLE; a held-low (break) line shall not start a new frame.
REQ-019 data_valid and frame_err shall be registered and high for exactly the one clk cycle after the deciding tick edge; never both high together.
REQ-020 data shall hold its value between valid frames.
REQ-021 A new start bit shall be accepted on the first tick in IDLE after a valid stop, so back-to-back frames need no extra idle time.
REQ-022 With tick held 0, no state, counter or output shall change (pulses remain 0).
REQ-023 Nominal latency: data_valid rises 1 clk after the tick at mid stop bit, i.e. 9.5 bit periods plus 2-3 clk (synchronizer) after the start-bit falling edge.

Reset
REQ-024 While rst=0 at a clk edge: state=IDLE, counter=0, bit index=0, shift register=0, data=8'h00, data_valid=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-025 Reset asserted mid-frame shall abandon the frame with no pulse; the first falling edge after release shall be treated as a new start bit.

Verification
REQ-026 tick every 4 clk; send frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> data=8'hA5, one data_valid pulse, frame_err=0, busy low after the pulse.
REQ-027 rxd low for 3 ticks then high -> FSM returns to IDLE from START, no data_valid or frame_err, data unchanged.
REQ-028 Send 0x3C with stop bit 0, hold low 40 ticks, then high -> one frame_err pulse, data keeps the previous 0xA5, FSM stays in WAIT_HIGH until rxd high, no false start.
REQ-029 Back-to-back frames 0x00 then 0xFF with no idle gap -> two data_valid pulses carrying 8'h00 then 8'hFF.
REQ-030 rst=0 during bit 4 of a frame, then send 0x5A -> all outputs 0 during reset, no pulse for the aborted frame, data=8'h5A after the new frame.
REQ-031 tick stuck at 0 while rxd toggles for 200 clk -> busy, data and pulses unchanged.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop input synchronizer plus an oversampling frame FSM.
// All FSM state advances only on baud ticks; pulses are registered and last one clk.
`timescale 1ns/1ps
module uart_rx_ctrl #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [3:0] CntMid  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] CntLast = 4'(OVERSAMPLE - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    logic                 rx_meta_q;
    logic                 rxs_q;
    state_e               state_q;
    logic [3:0]           cnt_q;
    logic [IdxW-1:0]      idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 data_valid_q;
    logic                 frame_err_q;

    // Synchronizer resets to the idle line level so reset release never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    StIdle: begin
                        if (!rxs_q) begin
                            state_q <= StStart;
                            cnt_q   <= '0;
                        end
                    end
                    StStart: begin
                        if (cnt_q == CntMid) begin
                            cnt_q <= '0;
                            idx_q <= '0;
                            // A start bit that is high again at mid-bit was a glitch.
                            state_q <= rxs_q ? StIdle : StData;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    StData: begin
                        if (cnt_q == CntLast) begin
                            shift_q <= {rxs_q, shift_q[DATA_BITS-1:1]};
                            cnt_q   <= '0;
                            idx_q   <= idx_q + 1'b1;
                            if (idx_q == IdxLast) begin
                                state_q <= StStop;
                            end
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    StStop: begin
                        if (cnt_q == CntLast) begin
                            cnt_q <= '0;
                            if (rxs_q) begin
                                data_q       <= shift_q;
                                data_valid_q <= 1'b1;
                                state_q      <= StIdle;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= StWaitHigh;
                            end
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                    StWaitHigh: begin
                        if (rxs_q) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames push expected pulses, a negedge monitor pops them.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          tick_en  = 1'b0;
    int          tick_phase = 0;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [7:0] last_good = 8'h00;

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .OVERSAMPLE(16),
        .DATA_BITS (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .rxd       (rxd),
        .data      (data),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-clk tick every 4 clk.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick_phase = (tick_phase + 1) % 4;
            tick = tick_en && (tick_phase == 0);
        end
    end

    // 16 ticks x 4 clk = 64 clk per bit.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        exp_t e;
        e.is_err = !stop_ok;
        e.data   = stop_ok ? b : last_good;
        sb_q.push_back(e);
        if (stop_ok) last_good = b;
        rxd = 1'b0;
        wait_clk(64);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_clk(64);
        end
        rxd = stop_ok;
        wait_clk(64);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) wait_clk(1);
        check_eq("sb_drain", sb_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst && (data_valid || frame_err)) begin
            check_eq("pulse_excl", {31'd0, data_valid & frame_err}, 0);
            if (sb_q.size() == 0) begin
                check_eq("spurious_pulse", {30'd0, data_valid, frame_err}, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("pulse_kind", {30'd0, data_valid, frame_err},
                         mon_e.is_err ? 32'd1 : 32'd2);
                check_eq("rx_data", data, mon_e.data);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ab;
        ab = 8'hC3;

        // Reset values
        wait_clk(5);
        @(negedge clk);
        check_eq("rst_data", data, 8'h00);
        check_eq("rst_dv", data_valid, 0);
        check_eq("rst_fe", frame_err, 0);
        check_eq("rst_busy", busy, 0);
        rst = 1'b1;
        tick_en = 1'b1;
        wait_clk(20);

        // Clean frame
        send_frame(8'hA5, 1'b1);
        wait_drain();
        @(negedge clk);
        check_eq("a5_data", data, 8'hA5);
        check_eq("a5_busy", busy, 0);

        // Start-bit glitch of 3 ticks
        rxd = 1'b0;
        wait_clk(12);
        @(negedge clk);
        check_eq("glitch_busy_in", busy, 1);
        wait_clk(1);
        rxd = 1'b1;
        wait_clk(80);
        @(negedge clk);
        check_eq("glitch_busy_out", busy, 0);
        check_eq("glitch_data", data, 8'hA5);

        // Framing error followed by a held break
        send_frame(8'h3C, 1'b0);
        wait_clk(160);
        @(negedge clk);
        check_eq("break_busy", busy, 1);
        check_eq("break_data", data, 8'hA5);
        wait_drain();
        rxd = 1'b1;
        wait_clk(40);
        @(negedge clk);
        check_eq("break_release_busy", busy, 0);

        // Back-to-back frames
        wait_clk(1);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_drain();
        @(negedge clk);
        check_eq("b2b_data", data, 8'hFF);

        // Reset during bit 4
        wait_clk(20);
        rxd = 1'b0;
        wait_clk(64);
        for (int i = 0; i < 4; i++) begin
            rxd = ab[i];
            wait_clk(64);
        end
        rxd = ab[4];
        wait_clk(32);
        rst = 1'b0;
        rxd = 1'b1;
        wait_clk(3);
        @(negedge clk);
        check_eq("mid_rst_data", data, 8'h00);
        check_eq("mid_rst_dv", data_valid, 0);
        check_eq("mid_rst_fe", frame_err, 0);
        check_eq("mid_rst_busy", busy, 0);
        last_good = 8'h00;
        wait_clk(5);
        rst = 1'b1;
        wait_clk(20);
        send_frame(8'h5A, 1'b1);
        wait_drain();
        @(negedge clk);
        check_eq("after_rst_data", data, 8'h5A);

        // Tick stuck low while the line toggles
        wait_clk(20);
        tick_en = 1'b0;
        wait_clk(2);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (i % 3 == 0) rxd = ~rxd;
            if (i % 20 == 19) begin
                @(negedge clk);
                check_eq("stuck_busy", busy, 0);
            end
        end
        @(negedge clk);
        check_eq("stuck_data", data, 8'h5A);
        wait_clk(1);
        rxd = 1'b1;
        wait_clk(4);
        tick_en = 1'b1;
        wait_clk(40);
        @(negedge clk);
        check_eq("final_busy", busy, 0);
        check_eq("final_sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
